rs_wakeup_select: RTL and testbench

- Parametrised reservation station for the out-of-order core; next generation of the single-ALU RS.
- Accepts decoded ALU/branch/JALR micro-ops from the decoder and holds them until both operands are valid.
- Snoops CDB_NUM broadcast channels for operand wake-up.
- Issues the oldest ready entry through a registered valid/ready output stage to a pipelined ALU.
- Sits between decoder/ROB allocation and the ALU; flushed on branch mispredict.

---
 rtl/rs_wakeup_select.sv | 207 ++++++++++++++++++++
 tb/tb_rs_wakeup_select.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_wakeup_select.sv
// Reservation station with CDB wake-up, same-cycle dispatch bypass,
// age-matrix oldest-first selection and a registered valid/ready issue stage.
module rs_wakeup_select #(
  parameter int RS_DEPTH  = 16,
  parameter int ROB_IDX_W = 4,
  parameter int CDB_NUM   = 2,
  parameter int XLEN      = 32,
  parameter int OP_W      = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           jump_wrong,
  input  logic                           dec_valid,
  input  logic [OP_W-1:0]                dec_op,
  input  logic                           dec_rs1_rdy,
  input  logic [XLEN-1:0]                dec_rs1,
  input  logic                           dec_rs2_rdy,
  input  logic [XLEN-1:0]                dec_rs2,
  input  logic [ROB_IDX_W-1:0]           dec_rob,
  output logic                           rs_full,
  output logic [$clog2(RS_DEPTH+1)-1:0]  rs_count,
  input  logic [CDB_NUM-1:0]             cdb_valid,
  input  logic [CDB_NUM*ROB_IDX_W-1:0]   cdb_rob,
  input  logic [CDB_NUM*XLEN-1:0]        cdb_val,
  output logic                           iss_valid,
  input  logic                           iss_ready,
  output logic [OP_W-1:0]                iss_op,
  output logic [XLEN-1:0]                iss_vj,
  output logic [XLEN-1:0]                iss_vk,
  output logic [ROB_IDX_W-1:0]           iss_rob
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RS_DEPTH+1);

  // Control state (reset)
  logic [RS_DEPTH-1:0] busy;
  // older_by[i][j] = 1 means entry j is older than entry i
  logic [RS_DEPTH-1:0] older_by [RS_DEPTH];

  // Entry payload (no reset; only meaningful while busy)
  logic [OP_W-1:0]      e_op  [RS_DEPTH];
  logic [XLEN-1:0]      e_vj  [RS_DEPTH];
  logic [XLEN-1:0]      e_vk  [RS_DEPTH];
  logic [ROB_IDX_W-1:0] e_qj  [RS_DEPTH];
  logic [ROB_IDX_W-1:0] e_qk  [RS_DEPTH];
  logic [ROB_IDX_W-1:0] e_rob [RS_DEPTH];
  logic [RS_DEPTH-1:0]  e_vj_ok;
  logic [RS_DEPTH-1:0]  e_vk_ok;

  // Derived per-cycle signals
  logic [RS_DEPTH-1:0]  elig;
  logic [RS_DEPTH-1:0]  alloc_mask;
  logic [RS_DEPTH-1:0]  issue_mask;
  logic [IDX_W-1:0]     alloc_idx;
  logic                 alloc_ok;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_ok;
  logic                 accept;
  logic                 load;
  logic                 byp1_hit;
  logic                 byp2_hit;
  logic [XLEN-1:0]      byp1_val;
  logic [XLEN-1:0]      byp2_val;
  logic [RS_DEPTH-1:0]  wj_hit;
  logic [RS_DEPTH-1:0]  wk_hit;
  logic [XLEN-1:0]      wj_val [RS_DEPTH];
  logic [XLEN-1:0]      wk_val [RS_DEPTH];

  // Returns {hit, value} for a tag against all CDB channels; lowest channel wins.
  function automatic logic [XLEN:0] cdb_match(
    input logic [ROB_IDX_W-1:0]         tag,
    input logic [CDB_NUM-1:0]           v,
    input logic [CDB_NUM*ROB_IDX_W-1:0] tags,
    input logic [CDB_NUM*XLEN-1:0]      vals
  );
    logic [XLEN:0] r;
    r = '0;
    for (int k = CDB_NUM-1; k >= 0; k--) begin
      if (v[k] && (tags[k*ROB_IDX_W +: ROB_IDX_W] == tag))
        r = {1'b1, vals[k*XLEN +: XLEN]};
    end
    return r;
  endfunction

  assign rs_full = &busy;
  assign elig    = busy & e_vj_ok & e_vk_ok;
  assign accept  = rdy && !jump_wrong && dec_valid && !rs_full;
  assign load    = rdy && !jump_wrong && sel_ok && (!iss_valid || iss_ready);

  // Lowest-index free entry, taken from stored busy only
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    alloc_ok  = 1'b0;
    alloc_idx = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (!busy[i]) begin
        alloc_ok  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  // Oldest eligible entry: nobody eligible is older than it
  always_comb begin
    sel_ok  = 1'b0;
    sel_idx = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (elig[i] && ((older_by[i] & elig) == '0)) begin
        sel_ok  = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // One-hot masks for the entry written and the entry freed this cycle
  always_comb begin
    alloc_mask = '0;
    issue_mask = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      alloc_mask[i] = accept && alloc_ok && (alloc_idx == IDX_W'(i));
      issue_mask[i] = load && (sel_idx == IDX_W'(i));
    end
  end

  // CDB matching for the dispatching op and for every stored pending operand
  always_comb begin
    {byp1_hit, byp1_val} = cdb_match(dec_rs1[ROB_IDX_W-1:0], cdb_valid, cdb_rob, cdb_val);
    {byp2_hit, byp2_val} = cdb_match(dec_rs2[ROB_IDX_W-1:0], cdb_valid, cdb_rob, cdb_val);
    for (int i = 0; i < RS_DEPTH; i++) begin
      {wj_hit[i], wj_val[i]} = cdb_match(e_qj[i], cdb_valid, cdb_rob, cdb_val);
      {wk_hit[i], wk_val[i]} = cdb_match(e_qk[i], cdb_valid, cdb_rob, cdb_val);
    end
  end

  // Busy bits, age matrix, occupancy count and issue register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= '0;
      rs_count  <= '0;
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_vj    <= '0;
      iss_vk    <= '0;
      iss_rob   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) older_by[i] <= '0;
    end else if (rdy) begin
      if (jump_wrong) begin
        busy      <= '0;
        rs_count  <= '0;
        iss_valid <= 1'b0;
      end else begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        busy <= (busy & ~issue_mask) | alloc_mask;
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (alloc_mask[i]) older_by[i] <= busy;
          else               older_by[i] <= older_by[i] & ~alloc_mask;
        end
        case ({accept, load})
          2'b10:   rs_count <= rs_count + CNT_W'(1);
          2'b01:   rs_count <= rs_count - CNT_W'(1);
          default: rs_count <= rs_count;
        endcase
        if (load) begin
          iss_valid <= 1'b1;
          iss_op    <= e_op[sel_idx];
          iss_vj    <= e_vj[sel_idx];
          iss_vk    <= e_vk[sel_idx];
          iss_rob   <= e_rob[sel_idx];
        end else if (iss_ready) begin
          iss_valid <= 1'b0;
        end
      end
    end
  end

  // Entry payload: dispatch write with same-cycle bypass, CDB wake-up otherwise
  // NOTE: payload storage has no reset; busy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (rdy && !jump_wrong) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (alloc_mask[i]) begin
          e_op[i]    <= dec_op;
          e_rob[i]   <= dec_rob;
          e_qj[i]    <= dec_rs1[ROB_IDX_W-1:0];
          e_qk[i]    <= dec_rs2[ROB_IDX_W-1:0];
          e_vj_ok[i] <= dec_rs1_rdy || byp1_hit;
          e_vk_ok[i] <= dec_rs2_rdy || byp2_hit;
          e_vj[i]    <= dec_rs1_rdy ? dec_rs1 : byp1_val;
          e_vk[i]    <= dec_rs2_rdy ? dec_rs2 : byp2_val;
        end else if (busy[i]) begin
          if (!e_vj_ok[i] && wj_hit[i]) begin
            e_vj[i]    <= wj_val[i];
            e_vj_ok[i] <= 1'b1;
          end
          if (!e_vk_ok[i] && wk_hit[i]) begin
            e_vk[i]    <= wk_val[i];
            e_vk_ok[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_wakeup_select.sv
// Directed testbench for rs_wakeup_select (default parameters).
module tb_rs_wakeup_select;

  localparam int RS_DEPTH  = 16;
  localparam int ROB_IDX_W = 4;
  localparam int CDB_NUM   = 2;
  localparam int XLEN      = 32;
  localparam int OP_W      = 6;
  localparam logic [OP_W-1:0] OP_ADD = 6'h01;
  localparam logic [OP_W-1:0] OP_SUB = 6'h02;

  logic                          clk;
  logic                          rst;
  logic                          rdy;
  logic                          jump_wrong;
  logic                          dec_valid;
  logic [OP_W-1:0]               dec_op;
  logic                          dec_rs1_rdy;
  logic [XLEN-1:0]               dec_rs1;
  logic                          dec_rs2_rdy;
  logic [XLEN-1:0]               dec_rs2;
  logic [ROB_IDX_W-1:0]          dec_rob;
  logic                          rs_full;
  logic [4:0]                    rs_count;
  logic [CDB_NUM-1:0]            cdb_valid;
  logic [CDB_NUM*ROB_IDX_W-1:0]  cdb_rob;
  logic [CDB_NUM*XLEN-1:0]       cdb_val;
  logic                          iss_valid;
  logic                          iss_ready;
  logic [OP_W-1:0]               iss_op;
  logic [XLEN-1:0]               iss_vj;
  logic [XLEN-1:0]               iss_vk;
  logic [ROB_IDX_W-1:0]          iss_rob;

  int passed = 0;
  int total  = 0;

  rs_wakeup_select #(
    .RS_DEPTH(RS_DEPTH), .ROB_IDX_W(ROB_IDX_W), .CDB_NUM(CDB_NUM),
    .XLEN(XLEN), .OP_W(OP_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .dec_valid(dec_valid), .dec_op(dec_op),
    .dec_rs1_rdy(dec_rs1_rdy), .dec_rs1(dec_rs1),
    .dec_rs2_rdy(dec_rs2_rdy), .dec_rs2(dec_rs2), .dec_rob(dec_rob),
    .rs_full(rs_full), .rs_count(rs_count),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_val(cdb_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_rob(iss_rob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dec(input logic [OP_W-1:0] op, input logic r1rdy, input logic [XLEN-1:0] r1,
                           input logic r2rdy, input logic [XLEN-1:0] r2, input logic [ROB_IDX_W-1:0] rob);
    dec_valid   = 1'b1;
    dec_op      = op;
    dec_rs1_rdy = r1rdy;
    dec_rs1     = r1;
    dec_rs2_rdy = r2rdy;
    dec_rs2     = r2;
    dec_rob     = rob;
  endtask

  task automatic clear_dec();
    dec_valid = 1'b0;
  endtask

  task automatic drive_cdb(input logic [1:0] v, input logic [3:0] rob0, input logic [XLEN-1:0] val0,
                           input logic [3:0] rob1, input logic [XLEN-1:0] val1);
    cdb_valid = v;
    cdb_rob   = {rob1, rob0};
    cdb_val   = {val1, val0};
  endtask

  task automatic clear_cdb();
    cdb_valid = '0;
  endtask

  task automatic test_reset();
    total++; if (iss_valid !== 1'b0) $display("FAIL reset_iss_valid got=%0b exp=0", iss_valid); else passed++;
    total++; if (rs_count !== 5'd0) $display("FAIL reset_rs_count got=%0d exp=0", rs_count); else passed++;
    total++; if (rs_full !== 1'b0) $display("FAIL reset_rs_full got=%0b exp=0", rs_full); else passed++;
    total++; if ({iss_op, iss_vj, iss_vk, iss_rob} !== '0)
      $display("FAIL reset_iss_payload got op=%h vj=%h vk=%h rob=%h exp=0", iss_op, iss_vj, iss_vk, iss_rob);
    else passed++;
  endtask

  task automatic test_ready_dispatch();
    iss_ready = 1'b1;
    drive_dec(OP_ADD, 1'b1, 32'd5, 1'b1, 32'd7, 4'd3);
    tick();
    clear_dec();
    total++; if (rs_count !== 5'd1) $display("FAIL rd_count_after_dispatch got=%0d exp=1", rs_count); else passed++;
    total++; if (iss_valid !== 1'b0) $display("FAIL rd_no_early_issue got=%0b exp=0", iss_valid); else passed++;
    tick();
    total++; if ({iss_valid, iss_op, iss_vj, iss_vk, iss_rob} !== {1'b1, OP_ADD, 32'd5, 32'd7, 4'd3})
      $display("FAIL rd_issue got v=%0b op=%h vj=%0d vk=%0d rob=%0d exp v=1 op=01 vj=5 vk=7 rob=3",
               iss_valid, iss_op, iss_vj, iss_vk, iss_rob);
    else passed++;
    total++; if (rs_count !== 5'd0) $display("FAIL rd_count_after_issue got=%0d exp=0", rs_count); else passed++;
    tick();
    total++; if (iss_valid !== 1'b0) $display("FAIL rd_drain got=%0b exp=0", iss_valid); else passed++;
  endtask

  task automatic test_bypass();
    iss_ready = 1'b1;
    drive_dec(OP_SUB, 1'b0, 32'd2, 1'b1, 32'd9, 4'd4);
    drive_cdb(2'b10, 4'd5, 32'hdead, 4'd2, 32'h1234);
    tick();
    clear_dec(); clear_cdb();
    total++; if (iss_valid !== 1'b0) $display("FAIL byp_no_early_issue got=%0b exp=0", iss_valid); else passed++;
    tick();
    total++; if ({iss_valid, iss_vj, iss_vk, iss_rob} !== {1'b1, 32'h1234, 32'd9, 4'd4})
      $display("FAIL byp_issue got v=%0b vj=%h vk=%0d rob=%0d exp v=1 vj=1234 vk=9 rob=4",
               iss_valid, iss_vj, iss_vk, iss_rob);
    else passed++;
    tick();
    // both channels match: channel 0 must win
    drive_dec(OP_ADD, 1'b1, 32'd1, 1'b0, 32'd2, 4'd6);
    drive_cdb(2'b11, 4'd2, 32'haaaa, 4'd2, 32'hbbbb);
    tick();
    clear_dec(); clear_cdb();
    tick();
    total++; if ({iss_valid, iss_vk, iss_rob} !== {1'b1, 32'haaaa, 4'd6})
      $display("FAIL byp_lowest_channel got v=%0b vk=%h rob=%0d exp v=1 vk=aaaa rob=6", iss_valid, iss_vk, iss_rob);
    else passed++;
    tick();
  endtask

  task automatic test_wakeup();
    iss_ready = 1'b1;
    drive_dec(OP_ADD, 1'b1, 32'h11, 1'b0, 32'd6, 4'd5);
    tick();
    clear_dec();
    drive_cdb(2'b10, 4'd0, 32'h0, 4'd7, 32'h77);   // non-matching tag
    tick();
    clear_cdb();
    total++; if (iss_valid !== 1'b0) $display("FAIL wk_wrong_tag got=%0b exp=0", iss_valid); else passed++;
    drive_cdb(2'b01, 4'd6, 32'h66, 4'd0, 32'h0);
    tick();
    clear_cdb();
    total++; if (iss_valid !== 1'b0) $display("FAIL wk_no_select_bypass got=%0b exp=0", iss_valid); else passed++;
    tick();
    total++; if ({iss_valid, iss_vj, iss_vk, iss_rob} !== {1'b1, 32'h11, 32'h66, 4'd5})
      $display("FAIL wk_issue got v=%0b vj=%h vk=%h rob=%0d exp v=1 vj=11 vk=66 rob=5",
               iss_valid, iss_vj, iss_vk, iss_rob);
    else passed++;
    tick();
    total++; if ({iss_valid, rs_count} !== {1'b0, 5'd0})
      $display("FAIL wk_drain got v=%0b cnt=%0d exp v=0 cnt=0", iss_valid, rs_count);
    else passed++;
  endtask

  task automatic test_oldest_first();
    // A pending, B ready, C ready, then wake A: order B, C, A
    iss_ready = 1'b1;
    drive_dec(OP_ADD, 1'b0, 32'd9, 1'b1, 32'd1, 4'd10); tick();
    drive_dec(OP_ADD, 1'b1, 32'd2, 1'b1, 32'd2, 4'd11); tick();
    drive_dec(OP_ADD, 1'b1, 32'd3, 1'b1, 32'd3, 4'd12); tick();
    clear_dec();
    total++; if ({iss_valid, iss_rob} !== {1'b1, 4'd11}) $display("FAIL of_first got v=%0b rob=%0d exp v=1 rob=11", iss_valid, iss_rob); else passed++;
    drive_cdb(2'b01, 4'd9, 32'h99, 4'd0, 32'h0);
    tick();
    clear_cdb();
    total++; if ({iss_valid, iss_rob} !== {1'b1, 4'd12}) $display("FAIL of_second got v=%0b rob=%0d exp v=1 rob=12", iss_valid, iss_rob); else passed++;
    tick();
    total++; if ({iss_valid, iss_rob, iss_vj} !== {1'b1, 4'd10, 32'h99})
      $display("FAIL of_third got v=%0b rob=%0d vj=%h exp v=1 rob=10 vj=99", iss_valid, iss_rob, iss_vj);
    else passed++;
    tick();
    // Age beats index: Q (entry 1) is older than R (entry 0)
    iss_ready = 1'b0;
    drive_dec(OP_ADD, 1'b1, 32'd1, 1'b1, 32'd1, 4'd1); tick();   // P -> iss at next edge
    drive_dec(OP_ADD, 1'b0, 32'd13, 1'b1, 32'd1, 4'd2); tick();  // Q pending, entry 1
    drive_dec(OP_ADD, 1'b1, 32'd3, 1'b1, 32'd3, 4'd3); tick();   // R ready, entry 0
    clear_dec();
    drive_cdb(2'b01, 4'd13, 32'hd, 4'd0, 32'h0);
    tick();
    clear_cdb();
    total++; if ({iss_valid, iss_rob, rs_count} !== {1'b1, 4'd1, 5'd2})
      $display("FAIL of_hold got v=%0b rob=%0d cnt=%0d exp v=1 rob=1 cnt=2", iss_valid, iss_rob, rs_count);
    else passed++;
    iss_ready = 1'b1;
    tick();
    total++; if (iss_rob !== 4'd2) $display("FAIL of_age_over_index got rob=%0d exp rob=2", iss_rob); else passed++;
    tick();
    total++; if (iss_rob !== 4'd3) $display("FAIL of_age_last got rob=%0d exp rob=3", iss_rob); else passed++;
    tick();
  endtask

  task automatic test_full_backpressure();
    logic [XLEN-1:0] base;
    base = 32'h100;
    iss_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      if (k == 16) begin
        total++; if ({rs_full, rs_count} !== {1'b0, 5'd15})
          $display("FAIL fb_not_yet_full got full=%0b cnt=%0d exp full=0 cnt=15", rs_full, rs_count);
        else passed++;
      end
      drive_dec(OP_ADD, 1'b1, base + XLEN'(k), 1'b1, 32'd0, 4'(k));
      tick();
    end
    total++; if ({rs_full, rs_count} !== {1'b1, 5'd16})
      $display("FAIL fb_full got full=%0b cnt=%0d exp full=1 cnt=16", rs_full, rs_count);
    else passed++;
    drive_dec(OP_SUB, 1'b1, 32'hbad, 1'b1, 32'hbad, 4'd15);   // dropped
    tick();
    clear_dec();
    total++; if ({rs_count, iss_valid, iss_vj, iss_rob} !== {5'd16, 1'b1, base, 4'd0})
      $display("FAIL fb_drop_stable got cnt=%0d v=%0b vj=%h rob=%0d exp cnt=16 v=1 vj=100 rob=0",
               rs_count, iss_valid, iss_vj, iss_rob);
    else passed++;
    iss_ready = 1'b1;
    tick();
    total++; if ({iss_vj, rs_count, rs_full} !== {base + 32'd1, 5'd15, 1'b0})
      $display("FAIL fb_first_release got vj=%h cnt=%0d full=%0b exp vj=101 cnt=15 full=0", iss_vj, rs_count, rs_full);
    else passed++;
    for (int k = 2; k < 17; k++) begin
      tick();
      total++; if ({iss_valid, iss_vj} !== {1'b1, base + XLEN'(k)})
        $display("FAIL fb_order_%0d got v=%0b vj=%h exp v=1 vj=%h", k, iss_valid, iss_vj, base + XLEN'(k));
      else passed++;
    end
    tick();
    total++; if ({iss_valid, rs_count} !== {1'b0, 5'd0})
      $display("FAIL fb_drained got v=%0b cnt=%0d exp v=0 cnt=0", iss_valid, rs_count);
    else passed++;
  endtask

  task automatic test_stall_flush();
    iss_ready = 1'b0;
    drive_dec(OP_ADD, 1'b1, 32'h77, 1'b1, 32'd0, 4'd2); tick();  // X
    drive_dec(OP_ADD, 1'b0, 32'd8, 1'b1, 32'd0, 4'd7);  tick();  // Y pending tag 8
    clear_dec();
    total++; if ({iss_valid, iss_vj, rs_count} !== {1'b1, 32'h77, 5'd1})
      $display("FAIL sf_setup got v=%0b vj=%h cnt=%0d exp v=1 vj=77 cnt=1", iss_valid, iss_vj, rs_count);
    else passed++;
    rdy = 1'b0;
    iss_ready = 1'b1;
    drive_cdb(2'b01, 4'd8, 32'h88, 4'd0, 32'h0);
    drive_dec(OP_ADD, 1'b1, 32'h55, 1'b1, 32'h55, 4'd9);
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if ({iss_valid, iss_vj, rs_count} !== {1'b1, 32'h77, 5'd1})
        $display("FAIL sf_stall_%0d got v=%0b vj=%h cnt=%0d exp v=1 vj=77 cnt=1", c, iss_valid, iss_vj, rs_count);
      else passed++;
    end
    clear_dec(); clear_cdb();
    rdy = 1'b1;
    tick();   // X drains; Y must still be pending
    total++; if ({iss_valid, rs_count} !== {1'b0, 5'd1})
      $display("FAIL sf_no_wake_in_stall got v=%0b cnt=%0d exp v=0 cnt=1", iss_valid, rs_count);
    else passed++;
    iss_ready = 1'b0;
    drive_dec(OP_ADD, 1'b1, 32'h33, 1'b1, 32'd0, 4'd11); tick();  // Z
    clear_dec();
    tick();
    total++; if ({iss_valid, iss_vj, rs_count} !== {1'b1, 32'h33, 5'd1})
      $display("FAIL sf_pre_flush got v=%0b vj=%h cnt=%0d exp v=1 vj=33 cnt=1", iss_valid, iss_vj, rs_count);
    else passed++;
    jump_wrong = 1'b1;
    iss_ready = 1'b1;
    drive_dec(OP_ADD, 1'b1, 32'h44, 1'b1, 32'd0, 4'd12);
    drive_cdb(2'b01, 4'd8, 32'h88, 4'd0, 32'h0);
    tick();
    jump_wrong = 1'b0;
    clear_dec(); clear_cdb();
    total++; if ({iss_valid, rs_count, rs_full} !== {1'b0, 5'd0, 1'b0})
      $display("FAIL sf_flush got v=%0b cnt=%0d full=%0b exp v=0 cnt=0 full=0", iss_valid, rs_count, rs_full);
    else passed++;
    drive_cdb(2'b01, 4'd8, 32'h88, 4'd0, 32'h0);
    tick();
    clear_cdb();
    tick();
    total++; if ({iss_valid, rs_count} !== {1'b0, 5'd0})
      $display("FAIL sf_after_flush got v=%0b cnt=%0d exp v=0 cnt=0", iss_valid, rs_count);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    iss_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_dec(OP_ADD, 1'b1, 32'h200 + XLEN'(k), 1'b1, 32'd0, 4'(k));
      tick();
    end
    clear_dec();
    total++; if ({iss_valid, rs_count} !== {1'b1, 5'd3})
      $display("FAIL rm_setup got v=%0b cnt=%0d exp v=1 cnt=3", iss_valid, rs_count);
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if ({iss_valid, rs_count, rs_full, iss_vj} !== {1'b0, 5'd0, 1'b0, 32'd0})
      $display("FAIL rm_async got v=%0b cnt=%0d full=%0b vj=%h exp all 0", iss_valid, rs_count, rs_full, iss_vj);
    else passed++;
    #3 rst = 1'b1;
    iss_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (iss_valid !== 1'b0) $display("FAIL rm_idle_%0d got v=%0b exp v=0", c, iss_valid); else passed++;
    end
    drive_dec(OP_SUB, 1'b1, 32'h5a, 1'b1, 32'ha5, 4'd8);
    tick();
    clear_dec();
    tick();
    total++; if ({iss_valid, iss_op, iss_vj, iss_vk, iss_rob} !== {1'b1, OP_SUB, 32'h5a, 32'ha5, 4'd8})
      $display("FAIL rm_new_dispatch got v=%0b op=%h vj=%h vk=%h rob=%0d exp v=1 op=02 vj=5a vk=a5 rob=8",
               iss_valid, iss_op, iss_vj, iss_vk, iss_rob);
    else passed++;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; jump_wrong = 1'b0; iss_ready = 1'b0;
    dec_valid = 1'b0; dec_op = '0; dec_rs1_rdy = 1'b0; dec_rs1 = '0;
    dec_rs2_rdy = 1'b0; dec_rs2 = '0; dec_rob = '0;
    cdb_valid = '0; cdb_rob = '0; cdb_val = '0;
    #12;
    test_reset();
    rst = 1'b1;
    tick();
    test_ready_dispatch();
    test_bypass();
    test_wakeup();
    test_oldest_first();
    test_full_backpressure();
    test_stall_flush();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
